phv_gather: RTL and testbench

- Return path of the action stage: collects per-container ALU results (6B, 4B and 2B groups) plus the untouched metadata and reassembles them into a full PHV for the next stage.
- Lane groups arrive with different pipeline latencies; the 4B group includes stateful load/store ops and is slower. The block aligns them in per-lane FIFOs and emits one PHV per matched set, with valid/ready backpressure toward upstream.

---
 rtl/phv_pkg.sv | 26 ++
 rtl/phv_lane_fifo.sv | 56 +++++
 rtl/phv_gather.sv | 154 +++++++++++++++
 tb/tb_phv_gather.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phv_pkg.sv
// rtl/phv_pkg.sv - shared PHV layout constants for the action stage
package phv_pkg;

  localparam int W_2B    = 16;
  localparam int W_4B    = 32;
  localparam int W_6B    = 48;
  localparam int N_CONT  = 8;
  localparam int META_W  = 256;
  localparam int PHV_LEN = N_CONT * (W_6B + W_4B + W_2B) + META_W;

  // Group offsets within the PHV, LSB first: META, 2B, 4B, 6B.
  localparam int OFF_META = 0;
  localparam int OFF_2B   = OFF_META + META_W;
  localparam int OFF_4B   = OFF_2B + N_CONT * W_2B;
  localparam int OFF_6B   = OFF_4B + N_CONT * W_4B;

  localparam int N_LANES = 4;

  typedef enum logic [1:0] {
    LANE_6B   = 2'd0,
    LANE_4B   = 2'd1,
    LANE_2B   = 2'd2,
    LANE_META = 2'd3
  } lane_e;

endpackage

// File: rtl/phv_lane_fifo.sv
// rtl/phv_lane_fifo.sv - in-order alignment FIFO for one PHV lane group
module phv_lane_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // A full lane still accepts a push when the same cycle frees a slot.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/phv_gather.sv
// rtl/phv_gather.sv - realigns skewed ALU lane results and metadata into one PHV
module phv_gather
  import phv_pkg::*;
#(
  parameter int STAGE_ID = 0,
  parameter int PHV_LEN  = 48*8+32*8+16*8+256,
  parameter int width_2B = 16,
  parameter int width_4B = 32,
  parameter int width_6B = 48,
  parameter int DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [width_6B*8-1:0]    alu_out_6B,
  input  logic                     alu_out_6B_valid,
  input  logic [width_4B*8-1:0]    alu_out_4B,
  input  logic                     alu_out_4B_valid,
  input  logic [width_2B*8-1:0]    alu_out_2B,
  input  logic                     alu_out_2B_valid,
  input  logic [255:0]             phv_remain_data,
  input  logic                     phv_remain_valid,
  output logic                     ready_out,
  output logic [PHV_LEN-1:0]       phv_out,
  output logic                     phv_out_valid,
  input  logic                     ready_in,
  output logic                     err_overflow,
  output logic [31:0]              phv_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int O2 = META_W;
  localparam int O4 = O2 + N_CONT * width_2B;
  localparam int O6 = O4 + N_CONT * width_4B;

  // Stage index is informational; an out-of-range value simply elaborates this empty block.
  if (STAGE_ID < 0) begin : g_stage_id_negative
  end

  logic [N_LANES-1:0]          lane_push;
  logic [N_LANES-1:0]          lane_empty;
  logic [N_LANES-1:0]          lane_full;
  logic [N_LANES-1:0]          lane_ovf;
  logic [N_LANES-1:0]          lane_ok;
  logic [CW-1:0]               lane_count [N_LANES];
  logic [N_CONT*width_6B-1:0]  dout_6b;
  logic [N_CONT*width_4B-1:0]  dout_4b;
  logic [N_CONT*width_2B-1:0]  dout_2b;
  logic [META_W-1:0]           dout_meta;
  logic [PHV_LEN-1:0]          phv_next;
  logic                        pop;

  always_comb begin
    lane_push            = '0;
    lane_push[LANE_6B]   = alu_out_6B_valid;
    lane_push[LANE_4B]   = alu_out_4B_valid;
    lane_push[LANE_2B]   = alu_out_2B_valid;
    lane_push[LANE_META] = phv_remain_valid;
  end

  // All lanes pop together, only when a full set is present and the output slot frees.
  assign pop = ~|lane_empty && (!phv_out_valid || ready_in);

  always_comb begin
    lane_ovf = '0;
    lane_ok  = '0;
    for (int i = 0; i < N_LANES; i++) begin
      lane_ovf[i] = lane_push[i] && lane_full[i] && !pop;
      lane_ok[i]  = (lane_count[i] + CW'(lane_push[i] && !lane_ovf[i]) - CW'(pop))
                    <= CW'(DEPTH - 2);
    end
  end

  always_comb begin
    phv_next                          = '0;
    phv_next[O6 +: N_CONT*width_6B]   = dout_6b;
    phv_next[O4 +: N_CONT*width_4B]   = dout_4b;
    phv_next[O2 +: N_CONT*width_2B]   = dout_2b;
    phv_next[META_W-1:0]              = dout_meta;
  end

  phv_lane_fifo #(.WIDTH(N_CONT*width_6B), .DEPTH(DEPTH)) u_lane_6b (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (lane_push[LANE_6B]),
    .din   (alu_out_6B),
    .pop   (pop),
    .dout  (dout_6b),
    .empty (lane_empty[LANE_6B]),
    .full  (lane_full[LANE_6B]),
    .count (lane_count[LANE_6B])
  );

  phv_lane_fifo #(.WIDTH(N_CONT*width_4B), .DEPTH(DEPTH)) u_lane_4b (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (lane_push[LANE_4B]),
    .din   (alu_out_4B),
    .pop   (pop),
    .dout  (dout_4b),
    .empty (lane_empty[LANE_4B]),
    .full  (lane_full[LANE_4B]),
    .count (lane_count[LANE_4B])
  );

  phv_lane_fifo #(.WIDTH(N_CONT*width_2B), .DEPTH(DEPTH)) u_lane_2b (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (lane_push[LANE_2B]),
    .din   (alu_out_2B),
    .pop   (pop),
    .dout  (dout_2b),
    .empty (lane_empty[LANE_2B]),
    .full  (lane_full[LANE_2B]),
    .count (lane_count[LANE_2B])
  );

  phv_lane_fifo #(.WIDTH(META_W), .DEPTH(DEPTH)) u_lane_meta (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (lane_push[LANE_META]),
    .din   (phv_remain_data),
    .pop   (pop),
    .dout  (dout_meta),
    .empty (lane_empty[LANE_META]),
    .full  (lane_full[LANE_META]),
    .count (lane_count[LANE_META])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phv_out       <= '0;
      phv_out_valid <= 1'b0;
      ready_out     <= 1'b1;
      err_overflow  <= 1'b0;
      phv_cnt       <= '0;
    end else begin
      if (pop) begin
        phv_out       <= phv_next;
        phv_out_valid <= 1'b1;
      end else if (ready_in) begin
        phv_out_valid <= 1'b0;
      end
      if (phv_out_valid && ready_in) begin
        phv_cnt <= phv_cnt + 32'd1;
      end
      if (|lane_ovf) begin
        err_overflow <= 1'b1;
      end
      // Two free slots per lane absorb the push issued while ready_out is falling.
      ready_out <= &lane_ok;
    end
  end

endmodule

// File: tb/tb_phv_gather.sv
// tb/tb_phv_gather.sv - directed vector and sequence bench for phv_gather
module tb_phv_gather;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [383:0]  alu_out_6B;
  logic          alu_out_6B_valid;
  logic [255:0]  alu_out_4B;
  logic          alu_out_4B_valid;
  logic [127:0]  alu_out_2B;
  logic          alu_out_2B_valid;
  logic [255:0]  phv_remain_data;
  logic          phv_remain_valid;
  logic          ready_out;
  logic [1023:0] phv_out;
  logic          phv_out_valid;
  logic          ready_in;
  logic          err_overflow;
  logic [31:0]   phv_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  phv_gather #(.STAGE_ID(0), .DEPTH(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alu_out_6B       (alu_out_6B),
    .alu_out_6B_valid (alu_out_6B_valid),
    .alu_out_4B       (alu_out_4B),
    .alu_out_4B_valid (alu_out_4B_valid),
    .alu_out_2B       (alu_out_2B),
    .alu_out_2B_valid (alu_out_2B_valid),
    .phv_remain_data  (phv_remain_data),
    .phv_remain_valid (phv_remain_valid),
    .ready_out        (ready_out),
    .phv_out          (phv_out),
    .phv_out_valid    (phv_out_valid),
    .ready_in         (ready_in),
    .err_overflow     (err_overflow),
    .phv_cnt          (phv_cnt)
  );

  typedef struct {
    logic [47:0]  c6_7;
    logic [31:0]  c4_0;
    logic [15:0]  c2_3;
    logic [255:0] meta;
    logic [47:0]  e_top;
    logic [31:0]  e_4b0;
    logic [15:0]  e_2b3;
    logic [255:0] e_meta;
    logic [31:0]  e_cnt;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [47:0] c6_7, input logic [31:0] c4_0,
                           input logic [15:0] c2_3, input logic [255:0] meta);
    alu_out_6B           = '0;
    alu_out_4B           = '0;
    alu_out_2B           = '0;
    alu_out_6B[383:336]  = c6_7;
    alu_out_4B[31:0]     = c4_0;
    alu_out_2B[63:48]    = c2_3;
    phv_remain_data      = meta;
  endtask

  // m = {6B, 4B, 2B, META}
  task automatic push(input logic [3:0] m);
    alu_out_6B_valid = m[3];
    alu_out_4B_valid = m[2];
    alu_out_2B_valid = m[1];
    phv_remain_valid = m[0];
    tick();
    alu_out_6B_valid = 1'b0;
    alu_out_4B_valid = 1'b0;
    alu_out_2B_valid = 1'b0;
    phv_remain_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_seen;
    vecs[0] = '{48'hAB, 32'h1234_5678, 16'hBEEF, 256'h1,
                48'hAB, 32'h1234_5678, 16'hBEEF, 256'h1, 32'd1};
    vecs[1] = '{48'hFFFF_FFFF_FFFF, 32'hFFFF_FFFF, 16'hFFFF, {256{1'b1}},
                48'hFFFF_FFFF_FFFF, 32'hFFFF_FFFF, 16'hFFFF, {256{1'b1}}, 32'd2};
    vecs[2] = '{48'h8000_0000_0001, 32'h8000_0001, 16'h8001, {1'b1, 255'b0},
                48'h8000_0000_0001, 32'h8000_0001, 16'h8001, {1'b1, 255'b0}, 32'd3};
    vecs[3] = '{48'h0, 32'h0, 16'h0, 256'h0,
                48'h0, 32'h0, 16'h0, 256'h0, 32'd4};

    rst_n = 1'b0;
    ready_in = 1'b0;
    alu_out_6B_valid = 1'b0;
    alu_out_4B_valid = 1'b0;
    alu_out_2B_valid = 1'b0;
    phv_remain_valid = 1'b0;
    set_lanes(48'h0, 32'h0, 16'h0, 256'h0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_valid", phv_out_valid, 1'b0);
    chk("rst_ready_out", ready_out, 1'b1);
    chk("rst_err", err_overflow, 1'b0);
    chk("rst_cnt", phv_cnt, 32'd0);
    chk("rst_phv_lo", phv_out[255:0], 256'h0);

    // Aligned single PHVs from the vector table
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_lanes(vecs[i].c6_7, vecs[i].c4_0, vecs[i].c2_3, vecs[i].meta);
      push(4'hF);
      chk("al_valid_e1", phv_out_valid, 1'b0);
      tick();
      chk("al_valid_e2", phv_out_valid, 1'b1);
      chk("al_6b7", phv_out[1023:976], vecs[i].e_top);
      chk("al_6b_rest", phv_out[975:720], 256'h0);
      chk("al_4b0", phv_out[415:384], vecs[i].e_4b0);
      chk("al_2b3", phv_out[319:304], vecs[i].e_2b3);
      chk("al_meta", phv_out[255:0], vecs[i].e_meta);
      tick();
      chk("al_cnt", phv_cnt, vecs[i].e_cnt);
      chk("al_valid_e3", phv_out_valid, 1'b0);
    end

    // Skewed: 4B arrives three cycles after the others
    set_lanes(48'h5A5A, 32'h5A5A_0004, 16'h5A02, 256'h5A00);
    push(4'b1011);
    chk("sk_wait0", phv_out_valid, 1'b0);
    tick();
    chk("sk_wait1", phv_out_valid, 1'b0);
    tick();
    chk("sk_wait2", phv_out_valid, 1'b0);
    push(4'b0100);
    chk("sk_wait3", phv_out_valid, 1'b0);
    tick();
    chk("sk_valid", phv_out_valid, 1'b1);
    chk("sk_6b7", phv_out[1023:976], 48'h5A5A);
    chk("sk_4b0", phv_out[415:384], 32'h5A5A_0004);
    chk("sk_2b3", phv_out[319:304], 16'h5A02);
    chk("sk_meta", phv_out[255:0], 256'h5A00);

    // Three back-to-back skewed PHVs keep their order
    for (int k = 0; k < 3; k++) begin
      set_lanes(48'h600 + 48'(k), 32'h0, 16'h200 + 16'(k), 256'h900 + 256'(k));
      push(4'b1011);
    end
    for (int k = 0; k < 3; k++) begin
      set_lanes(48'h0, 32'h400 + 32'(k), 16'h0, 256'h0);
      push(4'b0100);
      if (k == 0) begin
        chk("sk3_wait", phv_out_valid, 1'b0);
      end else begin
        chk("sk3_valid", phv_out_valid, 1'b1);
        chk("sk3_6b7", phv_out[1023:976], 48'h600 + 48'(k - 1));
        chk("sk3_4b0", phv_out[415:384], 32'h400 + 32'(k - 1));
        chk("sk3_meta", phv_out[255:0], 256'h900 + 256'(k - 1));
      end
    end
    tick();
    chk("sk3_valid_last", phv_out_valid, 1'b1);
    chk("sk3_4b0_last", phv_out[415:384], 32'h402);
    chk("sk3_2b3_last", phv_out[319:304], 16'h202);
    tick();
    chk("sk3_idle", phv_out_valid, 1'b0);
    chk("sk3_cnt", phv_cnt, 32'd8);

    // Backpressure: output holds PHV0 while three more fill the lanes
    ready_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_lanes(48'hB00 + 48'(k), 32'hB00 + 32'(k), 16'hB00 + 16'(k), 256'hB00 + 256'(k));
      push(4'hF);
      if (k == 0) begin
        chk("bp_valid0", phv_out_valid, 1'b0);
      end else begin
        chk("bp_hold_valid", phv_out_valid, 1'b1);
        chk("bp_hold_6b7", phv_out[1023:976], 48'hB00);
        chk("bp_hold_meta", phv_out[255:0], 256'hB00);
      end
      chk("bp_ready_out", ready_out, (k < 3));
    end
    tick();
    tick();
    chk("bp_stable_6b7", phv_out[1023:976], 48'hB00);
    chk("bp_stable_valid", phv_out_valid, 1'b1);
    chk("bp_ready_low", ready_out, 1'b0);
    ready_in = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("bp_out_valid", phv_out_valid, 1'b1);
      chk("bp_out_6b7", phv_out[1023:976], 48'hB00 + 48'(k));
      chk("bp_out_2b3", phv_out[319:304], 16'hB00 + 16'(k));
      chk("bp_ready_back", ready_out, 1'b1);
    end
    tick();
    chk("bp_idle", phv_out_valid, 1'b0);
    chk("bp_cnt", phv_cnt, 32'd12);
    chk("bp_err", err_overflow, 1'b0);

    // Overflow on the 2B lane only
    ready_in = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_lanes(48'h0, 32'h0, 16'hC00 + 16'(k), 256'h0);
      push(4'b0010);
      chk("ov_err", err_overflow, (k >= 4));
    end
    chk("ov_cnt6b", 32'(dut.u_lane_6b.count), 32'd0);
    chk("ov_cnt4b", 32'(dut.u_lane_4b.count), 32'd0);
    chk("ov_cntmeta", 32'(dut.u_lane_meta.count), 32'd0);
    chk("ov_cnt2b", 32'(dut.u_lane_2b.count), 32'd4);
    chk("ov_ready_out", ready_out, 1'b0);
    ready_in = 1'b1;
    n_seen = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc < 4) begin
        set_lanes(48'hD00 + 48'(cyc), 32'h0, 16'h0, 256'hD00 + 256'(cyc));
        push(4'b1101);
      end else begin
        tick();
      end
      if (phv_out_valid) begin
        chk("ov_drain_2b3", phv_out[319:304], 16'hC00 + 16'(n_seen));
        chk("ov_drain_6b7", phv_out[1023:976], 48'hD00 + 48'(n_seen));
        n_seen++;
      end
    end
    chk("ov_drain_n", n_seen, 4);
    chk("ov_err_sticky", err_overflow, 1'b1);
    chk("ov_cnt", phv_cnt, 32'd16);

    // Asynchronous reset mid-stream
    ready_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_lanes(48'hE00 + 48'(k), 32'hE00, 16'hE00, 256'hE00);
      push(4'hF);
    end
    chk("mr_pre_valid", phv_out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", phv_out_valid, 1'b0);
    chk("mr_phv_top", phv_out[1023:768], 256'h0);
    chk("mr_phv_lo", phv_out[255:0], 256'h0);
    chk("mr_ready_out", ready_out, 1'b1);
    chk("mr_err", err_overflow, 1'b0);
    chk("mr_cnt", phv_cnt, 32'd0);
    chk("mr_lane", 32'(dut.u_lane_2b.count), 32'd0);
    tick();
    rst_n = 1'b1;
    ready_in = 1'b1;
    set_lanes(48'hF00, 32'hF01, 16'hF02, 256'hF03);
    push(4'hF);
    chk("mr_new_wait", phv_out_valid, 1'b0);
    tick();
    chk("mr_new_valid", phv_out_valid, 1'b1);
    chk("mr_new_6b7", phv_out[1023:976], 48'hF00);
    chk("mr_new_4b0", phv_out[415:384], 32'hF01);
    tick();
    chk("mr_new_cnt", phv_cnt, 32'd1);

    // Counter wrap
    force dut.phv_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.phv_cnt;
    chk("wr_forced", phv_cnt, 32'hFFFF_FFFF);
    set_lanes(48'h77, 32'h77, 16'h77, 256'h77);
    push(4'hF);
    chk("wr_hold", phv_cnt, 32'hFFFF_FFFF);
    tick();
    chk("wr_valid", phv_out_valid, 1'b1);
    tick();
    chk("wr_cnt", phv_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
